// File: rtl/traffic_display_driver_pkg.sv
// Shared encodings for the traffic display driver: light states, converter
// states and active-low gfedcba segment patterns.
package traffic_pkg;

    localparam logic [1:0] ST_RED    = 2'b00;
    localparam logic [1:0] ST_GREEN  = 2'b01;
    localparam logic [1:0] ST_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_G     = 7'b1000010;
    localparam logic [6:0] SEG_Y     = 7'b0010001;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/traffic_display_driver_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to hundreds/tens/ones BCD over
// IDLE -> SHIFT (8 cycles) -> DONE. Outputs are valid while done is high.
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state, state_next;
    // {hundreds[1:0], tens, ones, remaining binary}
    logic [17:0] work, adj;
    logic [2:0]  shift_cnt;

    always_comb begin
        adj = work;
        if (work[15:12] >= 4'd5) adj[15:12] = work[15:12] + 4'd3;
        if (work[11:8]  >= 4'd5) adj[11:8]  = work[11:8]  + 4'd3;
    end

    always_comb begin
        state_next = state;
        case (state)
            CONV_IDLE:  if (start) state_next = CONV_SHIFT;
            CONV_SHIFT: if (shift_cnt == 3'd7) state_next = CONV_DONE;
            CONV_DONE:  state_next = CONV_IDLE;
            default:    state_next = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CONV_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                CONV_IDLE: if (start) begin
                    work      <= {10'd0, bin};
                    shift_cnt <= '0;
                end
                CONV_SHIFT: begin
                    work      <= adj << 1;
                    shift_cnt <= shift_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != CONV_IDLE);
    assign done     = (state == CONV_DONE);
    assign hundreds = work[17:16];
    assign tens     = work[15:12];
    assign ones     = work[11:8];

endmodule

// File: rtl/traffic_display_driver.sv
// Lamp driver, blink phase generator and 4-digit multiplexed 7-seg scanner
// for the traffic FSM. Define DP_PHASE_EN to flash the d0 decimal point.
module traffic_display_driver
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state_i,
    input  logic       blink_i,
    input  logic [7:0] countdown_i,
    output logic       lamp_red,
    output logic       lamp_green,
    output logic       lamp_yellow,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    logic [7:0]         last_val;
    logic               conv_start, conv_busy, conv_done;
    logic [1:0]         conv_h, disp_h;
    logic [3:0]         conv_t, conv_o, disp_t, disp_o;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_next;
    logic               phase, phase_next, blink_q;
    logic               dp0;
    logic [7:0]         seg_next;

    // A mismatch seen while busy is simply retried once the converter idles.
    assign conv_start = (countdown_i != last_val) && !conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .bin      (countdown_i),
        .busy     (conv_busy),
        .done     (conv_done),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val <= '0;
            disp_h   <= '0;
            disp_t   <= '0;
            disp_o   <= '0;
        end else begin
            if (conv_start) last_val <= countdown_i;
            if (conv_done) begin
                disp_h <= conv_h;
                disp_t <= conv_t;
                disp_o <= conv_o;
            end
        end
    end

    // A fresh blink request restarts with a full on-period, overriding a wrap.
    always_comb begin
        blink_cnt_next = blink_cnt + 1'b1;
        phase_next     = phase;
        if (blink_i && !blink_q) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase;
        end
    end

`ifdef DP_PHASE_EN
    assign dp0 = ~(blink_i & phase);
`else
    assign dp0 = 1'b1;
`endif

    always_comb begin
        seg_next = {1'b1, SEG_BLANK};
        case (digit_idx)
            2'd0: seg_next = {dp0, seg_digit(disp_o)};
            2'd1: if (disp_h != 2'd0 || disp_t != 4'd0)
                      seg_next = {1'b1, seg_digit(disp_t)};
            2'd2: if (disp_h != 2'd0)
                      seg_next = {1'b1, seg_digit({2'b00, disp_h})};
            2'd3: case (state_i)
                      ST_RED:    seg_next = {1'b1, SEG_R};
                      ST_GREEN:  seg_next = {1'b1, SEG_G};
                      ST_YELLOW: seg_next = {1'b1, SEG_Y};
                      default:   seg_next = {1'b1, SEG_DASH};
                  endcase
            default: seg_next = {1'b1, SEG_BLANK};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            phase       <= 1'b1;
            blink_q     <= 1'b0;
            lamp_red    <= 1'b0;
            lamp_green  <= 1'b0;
            lamp_yellow <= 1'b0;
            an          <= '1;
            seg         <= '1;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt  <= scan_cnt + 1'b1;
            end
            blink_cnt   <= blink_cnt_next;
            phase       <= phase_next;
            blink_q     <= blink_i;
            lamp_red    <= (state_i == ST_RED);
            lamp_yellow <= (state_i == ST_YELLOW);
            lamp_green  <= (state_i == ST_GREEN) && (!blink_i || phase_next);
            an          <= ~(4'b0001 << digit_idx);
            seg         <= seg_next;
        end
    end

endmodule

// File: tb/tb_traffic_display_driver.sv
// Directed bench for traffic_display_driver with SCAN_DIV=4, BLINK_DIV=8.
module tb_traffic_display_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_i = 2'b00;
    logic       blink_i = 1'b0;
    logic [7:0] countdown_i = 8'd0;
    logic       lamp_red, lamp_green, lamp_yellow;
    logic [3:0] an;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;

    traffic_display_driver #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .state_i     (state_i),
        .blink_i     (blink_i),
        .countdown_i (countdown_i),
        .lamp_red    (lamp_red),
        .lamp_green  (lamp_green),
        .lamp_yellow (lamp_yellow),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for the requested anode and returns the segment value.
    task automatic get_digit(input logic [3:0] want, output logic [7:0] s, output bit found);
        found = 1'b0;
        s = 8'hxx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == want) begin
                s = seg;
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        bit f;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 8'hFF || {lamp_red, lamp_green, lamp_yellow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async an=%b seg=%h lamps=%b expected an=1111 seg=ff lamps=000",
                     an, seg, {lamp_red, lamp_green, lamp_yellow});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_first_digit an=%b seg=%h expected an=1110 seg=c0", an, seg);
        end
        checks++;
        if (lamp_red !== 1'b1) begin
            errors++;
            $display("FAIL reset_lamp_red got %b expected 1", lamp_red);
        end
        get_digit(4'b1101, s, f);
        checks++;
        if (!f || s !== 8'hFF) begin
            errors++;
            $display("FAIL reset_d1_blank got %h found %0d expected ff", s, f);
        end
        get_digit(4'b1011, s, f);
        checks++;
        if (!f || s !== 8'hFF) begin
            errors++;
            $display("FAIL reset_d2_blank got %h found %0d expected ff", s, f);
        end
    endtask

    task automatic test_countdown9();
        logic [7:0] s;
        bit f;
        @(negedge clk);
        countdown_i = 8'd9;
        repeat (12) @(negedge clk);
        get_digit(4'b1110, s, f);
        checks++;
        if (!f || s !== 8'b10010000) begin
            errors++;
            $display("FAIL cd9_d0 got %h expected 90", s);
        end
        get_digit(4'b1101, s, f);
        checks++;
        if (!f || s !== 8'hFF) begin
            errors++;
            $display("FAIL cd9_d1 got %h expected ff", s);
        end
        get_digit(4'b1011, s, f);
        checks++;
        if (!f || s !== 8'hFF) begin
            errors++;
            $display("FAIL cd9_d2 got %h expected ff", s);
        end
        get_digit(4'b0111, s, f);
        checks++;
        if (!f || s !== 8'hAF) begin
            errors++;
            $display("FAIL cd9_d3_r got %h expected af", s);
        end
        checks++;
        if (lamp_red !== 1'b1 || lamp_green !== 1'b0 || lamp_yellow !== 1'b0) begin
            errors++;
            $display("FAIL cd9_lamps got %b expected 100", {lamp_red, lamp_green, lamp_yellow});
        end
    endtask

    task automatic test_numbers();
        logic [7:0] s;
        bit f;
        logic [7:0] vals [4] = '{8'd128, 8'd105, 8'd255, 8'd5};
        // expected {d2, d1, d0}
        logic [23:0] exp [4] = '{{8'hF9, 8'hA4, 8'h80}, {8'hF9, 8'hC0, 8'h92},
                                 {8'hA4, 8'h92, 8'h92}, {8'hFF, 8'hFF, 8'h92}};
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            countdown_i = vals[v];
            repeat (12) @(negedge clk);
            get_digit(4'b1110, s, f);
            checks++;
            if (!f || s !== exp[v][7:0]) begin
                errors++;
                $display("FAIL num%0d_d0 got %h expected %h", vals[v], s, exp[v][7:0]);
            end
            get_digit(4'b1101, s, f);
            checks++;
            if (!f || s !== exp[v][15:8]) begin
                errors++;
                $display("FAIL num%0d_d1 got %h expected %h", vals[v], s, exp[v][15:8]);
            end
            get_digit(4'b1011, s, f);
            checks++;
            if (!f || s !== exp[v][23:16]) begin
                errors++;
                $display("FAIL num%0d_d2 got %h expected %h", vals[v], s, exp[v][23:16]);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] s;
        bit f;
        logic expv;
        @(negedge clk);
        state_i = 2'b01;
        blink_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({lamp_red, lamp_green, lamp_yellow} !== 3'b010) begin
            errors++;
            $display("FAIL green_steady lamps=%b expected 010", {lamp_red, lamp_green, lamp_yellow});
        end
        get_digit(4'b0111, s, f);
        checks++;
        if (!f || s !== 8'hC2) begin
            errors++;
            $display("FAIL green_d3_G got %h expected c2", s);
        end
        blink_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            expv = ((k / 8) % 2) == 0;
            checks++;
            if (lamp_green !== expv) begin
                errors++;
                $display("FAIL blink_k%0d lamp_green=%b expected %b", k, lamp_green, expv);
            end
        end
        blink_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (lamp_green !== 1'b1) begin
                errors++;
                $display("FAIL blink_off_k%0d lamp_green=%b expected 1", k, lamp_green);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] prev;
        bit f;
        f = 1'b0;
        prev = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev == 4'b0111) begin
                f = 1'b1;
                break;
            end
            prev = an;
        end
        checks++;
        if (!f) begin
            errors++;
            $display("FAIL retrig_align an=%b expected d0 window start", an);
        end
        // Timeline: 9 starts on the next edge; 5 arrives during the 3rd SHIFT cycle.
        repeat (5) @(negedge clk);
        countdown_i = 8'd9;
        repeat (3) @(negedge clk);
        countdown_i = 8'd5;
        repeat (8) @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 8'h90) begin
            errors++;
            $display("FAIL retrig_shows9 an=%b seg=%h expected an=1110 seg=90", an, seg);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 8'h92) begin
            errors++;
            $display("FAIL retrig_shows5 an=%b seg=%h expected an=1110 seg=92", an, seg);
        end
    endtask

    task automatic test_illegal_state();
        logic [7:0] s;
        bit f;
        logic [7:0] expv;
        @(negedge clk);
        state_i = 2'b10;
        @(negedge clk);
        checks++;
        if ({lamp_red, lamp_green, lamp_yellow} !== 3'b001) begin
            errors++;
            $display("FAIL yellow_lamps got %b expected 001", {lamp_red, lamp_green, lamp_yellow});
        end
        get_digit(4'b0111, s, f);
        checks++;
        if (!f || s !== 8'h91) begin
            errors++;
            $display("FAIL yellow_d3_y got %h expected 91", s);
        end
        state_i = 2'b11;
        @(negedge clk);
        checks++;
        if ({lamp_red, lamp_green, lamp_yellow} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_lamps got %b expected 000", {lamp_red, lamp_green, lamp_yellow});
        end
        get_digit(4'b0111, s, f);
        checks++;
        if (!f || s !== 8'hBF) begin
            errors++;
            $display("FAIL illegal_d3_dash got %h expected bf", s);
        end
        blink_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k >= 1 && an == 4'b1110) begin
`ifdef DP_PHASE_EN
                expv = {~((((k - 1) / 8) % 2) == 0), 7'b0010010};
`else
                expv = 8'h92;
`endif
                checks++;
                if (seg !== expv) begin
                    errors++;
                    $display("FAIL dp_k%0d seg=%h expected %h", k, seg, expv);
                end
            end
            checks++;
            if (lamp_green !== 1'b0) begin
                errors++;
                $display("FAIL illegal_blink_green_k%0d got %b expected 0", k, lamp_green);
            end
        end
        blink_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_countdown9();
        test_numbers();
        test_blink();
        test_retrigger();
        test_illegal_state();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_display_driver.md
Name: traffic_display_driver

Overview:
- Downstream consumer of the traffic-light FSM's state (2-bit), blink flag and 8-bit countdown.
- Drives three lamp outputs with blink gating.
- Converts countdown to BCD with a sequential double-dabble converter.
- Scans a 4-digit common-anode 7-segment display: three countdown digits plus a state letter.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays selected (>=2)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
state_i  in  2  light state: 00 red, 01 green, 10 yellow, 11 illegal
blink_i  in  1  1 = green lamp must flash
countdown_i  in  8  seconds remaining, unsigned 0..255
lamp_red  out  1  red lamp, active-high
lamp_green  out  1  green lamp, active-high
lamp_yellow  out  1  yellow lamp, active-high
an  out  4  digit anodes, active-low, one-hot; an[0] = ones digit
seg  out  8  segments, active-low; seg[6:0] = g..a, seg[7] = dp

Behaviour:
Reset values:
- lamps 0; an=4'b1111; seg=8'hFF.
- BCD registers 0; last-converted value 0; converter IDLE.
- Digit index 0; scan counter 0; blink counter 0; blink phase 1.
- Reset mid-conversion aborts the conversion; nothing is latched.

Converter FSM (IDLE, SHIFT, DONE):
- IDLE -> SHIFT when countdown_i != last-converted value. At this transition: operand captured, shift count = 0, last-converted := operand.
- SHIFT runs exactly 8 cycles. Each cycle: add 3 to any BCD nibble >=5, then shift left one bit.
- DONE lasts 1 cycle: latches hundreds (0..2), tens and ones into display registers, then returns to IDLE.
- Latency from start to registers updated: 10 cycles.
- countdown_i changes during SHIFT/DONE are ignored. The mismatch retriggers a conversion from IDLE, so the final value always converges.

Scan:
- Scan counter counts 0..SCAN_DIV-1. At wrap, digit index increments mod 4 (3 wraps to 0).
- an and seg are registered: they update 1 cycle after the index changes.

Digit contents:
- d0 = ones, always shown.
- d1 = tens, blank if hundreds==0 and tens==0.
- d2 = hundreds, blank if 0.
- d3 = state letter: 00 'r' (7'b0101111), 01 'G' (7'b1000010), 10 'y' (7'b0010001), 11 '-' (7'b0111111).
- Digit codes are standard common-anode gfedcba, e.g. '9' = 7'b0010000.
- A blanked digit drives seg=8'hFF while its anode is still selected. Anode rotation never skips a digit.

Lamps:
- lamp_red = state_i==00; lamp_yellow = state_i==10.
- lamp_green = state_i==01 & (~blink_i | phase).
- State 11: all lamps 0.
- Lamps are registered, 1-cycle latency from inputs.

Blink phase:
- Blink counter counts 0..BLINK_DIV-1; phase toggles at wrap.
- A rising edge of blink_i (registered copy) forces phase=1 and counter=0. This guarantees a full on-period first.
- Rising edge and wrap in the same cycle: the rising edge wins.

Optional Feature:
- Macro: DP_PHASE_EN.
- Defined: dp (seg[7]) on d0 is 0 (lit) whenever blink_i==1 and phase==1, giving a visual second tick. All other digits keep dp=1.
- Undefined: seg[7]=1 always; no extra logic.

Decomposition:
- Package traffic_pkg holds:
  - state encodings ST_RED=2'b00, ST_GREEN=2'b01, ST_YELLOW=2'b10.
  - segment constants SEG_0..SEG_9, SEG_R, SEG_G, SEG_Y, SEG_DASH, SEG_BLANK.
  - converter state encodings.
- Sub-module bin2bcd_seq:
  - ports clk, rst, start, bin[7:0], busy, done, hundreds[1:0], tens[3:0], ones[3:0].
  - Owns the IDLE/SHIFT/DONE FSM.
- Top level holds the change detect, scan, blink and output registers.

Test Plan (SCAN_DIV=4, BLINK_DIV=8):
1. Reset: assert rst mid-run -> an=1111, seg=FF, lamps 0 immediately. Release -> first anode 1110 shows '0' on d0, d1/d2 blank.
2. Red, countdown 9: within 10 cycles, while an=1110 -> seg=8'b10010000. d3 -> 'r'. d1/d2 FF. lamp_red=1.
3. countdown 128 -> d2 '1', d1 '2', d0 '8', no blanking. Then countdown 5 -> d1/d2 blank.
4. state 01, blink_i rises -> lamp_green 1 for 8 cycles, 0 for 8, repeating. blink_i=0 -> steady 1.
5. countdown 9 then 5 on the 3rd SHIFT cycle -> display shows 9, then 5 within 20 cycles of the change.
6. state 11 -> all lamps 0, d3 shows 7'b0111111. With DP_PHASE_EN and blink_i=1 -> dp on d0 follows phase.
